load_writeback_unit: RTL

//  Multi-cycle load path that sits directly upstream of the register file write port.

---
 rtl/load_writeback_unit_pkg.sv | 27 ++
 rtl/load_writeback_unit_extract.sv | 28 ++
 rtl/load_writeback_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/load_writeback_unit_pkg.sv
// Shared definitions for the load/writeback path: RV32I load encodings and FSM states.
package load_writeback_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    WB   = 2'b11
  } state_t;

  // True for encodings that are not loads, or loads whose address breaks natural alignment.
  function automatic logic load_is_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: load_is_bad = 1'b0;
      F3_LH, F3_LHU: load_is_bad = addr_lo[0];
      F3_LW:         load_is_bad = (addr_lo != 2'b00);
      default:       load_is_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_writeback_unit_extract.sv
// Byte/half/word lane selection and sign/zero extension of a little-endian memory word.
module load_extract
  import load_writeback_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    byte_lane = word[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    data      = word;
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  data = {16'h0, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load path: memory req/ready handshake, timeout, and a one-cycle register file write.
module load_writeback_unit
  import load_writeback_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall,
  output logic        fault
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic [31:0] rdata_q;
  logic [7:0]  wait_count;
  logic        reject_q;
  logic        bad;
  logic        accept;
  logic        timeout;
  logic        in_mem;
  logic [31:0] extracted;

  assign bad     = load_is_bad(ld_funct3, ld_addr[1:0]);
  assign accept  = (state == IDLE) && ld_valid && !bad;
  assign in_mem  = (state == REQ) || (state == WAIT);
  // Ready in the final WAIT cycle takes priority over the timeout.
  assign timeout = (state == WAIT) && !mem_ready && (wait_count == TIMEOUT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     state_next = mem_ready ? WB : WAIT;
      WAIT:    if (mem_ready) state_next = WB;
               else if (timeout) state_next = IDLE;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      wait_count <= '0;
      reject_q   <= 1'b0;
    end else begin
      state    <= state_next;
      reject_q <= (state == IDLE) && ld_valid && bad;
      if (accept) begin
        funct3_q <= ld_funct3;
        addr_q   <= ld_addr;
        rd_q     <= ld_rd;
      end
      if (in_mem && mem_ready) rdata_q <= mem_rdata;
      if (state == REQ)       wait_count <= '0;
      else if (state == WAIT) wait_count <= wait_count + 8'd1;
    end
  end

  load_extract u_extract (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .word    (rdata_q),
    .data    (extracted)
  );

  assign mem_req  = in_mem;
  assign mem_addr = in_mem ? {addr_q[31:2], 2'b00} : 32'h0;
  assign stall    = in_mem || accept;
  assign fault    = reject_q || timeout;
  assign rf_we    = (state == WB) && (rd_q != 5'd0);
  assign rf_waddr = (state == WB) ? rd_q : 5'd0;
  assign rf_wdata = (state == WB) ? extracted : 32'h0;

endmodule
